rst_release_seq: RTL and testbench

- Consumer end of the stretched reset request produced by the clock/reset generator.
- Synchronises the request into clk, filters glitches, then releases NUM_DOM downstream domain resets one at a time, in index order.
- Each release waits for a per-domain acknowledge and a fixed gap before the next.
- Reports sequence completion, or a timeout error naming the failing domain.

---
 rtl/rst_release_seq_if.sv | 23 ++
 rtl/rst_release_seq.sv | 159 +++++++++++++++
 tb/tb_rst_release_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rst_release_seq_if.sv
// Handshake bundle between the reset release sequencer and its downstream domains.
interface rst_release_seq_if #(
   parameter int NUM_DOM = 3
);
   localparam int ERR_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

   logic               rst_req_in;
   logic [NUM_DOM-1:0] dom_ack;
   logic [NUM_DOM-1:0] dom_rst_out;
   logic               seq_done;
   logic               seq_err;
   logic [ERR_W-1:0]   err_dom;

   modport master (
      output rst_req_in, dom_ack,
      input  dom_rst_out, seq_done, seq_err, err_dom
   );

   modport slave (
      input  rst_req_in, dom_ack,
      output dom_rst_out, seq_done, seq_err, err_dom
   );
endinterface

// File: rtl/rst_release_seq.sv
// Synchronises and filters a stretched reset request, then releases downstream
// domain resets one at a time, waiting for each ack plus a fixed gap.
module rst_release_seq #(
   parameter int NUM_DOM     = 3,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_CYC  = 4,
   parameter int GAP_CYC     = 12,
   parameter int ACK_TIMEOUT = 255
) (
   input logic              clk,
   input logic              rst,
   rst_release_seq_if.slave bus
);
   localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
   localparam int CNT_MAX = (FILTER_CYC > GAP_CYC) ? FILTER_CYC : GAP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int TMR_W   = $clog2(ACK_TIMEOUT + 1);

   localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

   typedef enum logic [2:0] {HOLD, FILTER, RELEASE, WAIT_ACK, GAP, DONE, ERR} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [TMR_W-1:0]   tmr, tmr_nx;
   logic [IDX_W-1:0]   idx, idx_nx, idx_inc;
   logic [NUM_DOM-1:0] dom_rst, dom_rst_nx;
   logic               done_q, done_nx;
   logic               err_q, err_nx;
   logic [IDX_W-1:0]   err_dom_q, err_dom_nx;
   logic [SYNC_STAGES-1:0] sync_q;
   logic               sync_req;
   logic               aset;

   // The request forces the synchroniser and domain resets high with no clock.
   assign aset = rst | bus.rst_req_in;

   always_ff @(posedge clk or posedge aset) begin
      if (aset) sync_q <= '1;
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
   end

   assign sync_req = sync_q[SYNC_STAGES-1];
   assign idx_inc  = idx + 1'b1;

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      tmr_nx     = tmr;
      idx_nx     = idx;
      dom_rst_nx = dom_rst;
      done_nx    = done_q;
      err_nx     = err_q;
      err_dom_nx = err_dom_q;
      if (sync_req && state != HOLD) begin
         state_nx   = HOLD;
         cnt_nx     = '0;
         tmr_nx     = '0;
         idx_nx     = '0;
         dom_rst_nx = '1;
         done_nx    = 1'b0;
         err_nx     = 1'b0;
      end else begin
         case (state)
            HOLD: begin
               dom_rst_nx = '1;
               done_nx    = 1'b0;
               err_nx     = 1'b0;
               if (!sync_req) begin
                  state_nx = FILTER;
                  cnt_nx   = '0;
               end
            end
            FILTER: begin
               if (cnt == FILT_LAST) begin
                  state_nx      = RELEASE;
                  idx_nx        = '0;
                  cnt_nx        = '0;
                  dom_rst_nx[0] = 1'b0;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            RELEASE: begin
               state_nx = WAIT_ACK;
               tmr_nx   = '0;
            end
            WAIT_ACK: begin
               // Ack is checked first so it wins over a same-edge timeout.
               if (bus.dom_ack[idx]) begin
                  if (idx == IDX_LAST) begin
                     state_nx = DONE;
                     done_nx  = 1'b1;
                  end else begin
                     state_nx = GAP;
                     cnt_nx   = '0;
                  end
               end else if (tmr == TMR_LAST) begin
                  state_nx   = ERR;
                  err_nx     = 1'b1;
                  err_dom_nx = idx;
                  dom_rst_nx = '1;
               end else begin
                  tmr_nx = tmr + 1'b1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  state_nx            = RELEASE;
                  idx_nx              = idx_inc;
                  cnt_nx              = '0;
                  dom_rst_nx[idx_inc] = 1'b0;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            DONE: done_nx = 1'b1;
            ERR: begin
               err_nx     = 1'b1;
               dom_rst_nx = '1;
            end
            default: state_nx = HOLD;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= HOLD;
         cnt       <= '0;
         tmr       <= '0;
         idx       <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_dom_q <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         tmr       <= tmr_nx;
         idx       <= idx_nx;
         done_q    <= done_nx;
         err_q     <= err_nx;
         err_dom_q <= err_dom_nx;
      end
   end

   always_ff @(posedge clk or posedge aset) begin
      if (aset) dom_rst <= '1;
      else      dom_rst <= dom_rst_nx;
   end

   assign bus.dom_rst_out = dom_rst;
   assign bus.seq_done    = done_q;
   assign bus.seq_err     = err_q;
   assign bus.err_dom     = err_dom_q;
endmodule

// File: tb/tb_rst_release_seq.sv
// Directed bench for rst_release_seq: default instance plus a short-timeout instance.
module tb_rst_release_seq;
   logic clk = 1'b0;
   logic rst;
   int   nvec = 0;
   int   nerr = 0;

   logic [2:0] p1, p2, p3, ack_mask;
   logic       ack_all;

   rst_release_seq_if #(.NUM_DOM(3)) if1 ();
   rst_release_seq_if #(.NUM_DOM(3)) if2 ();

   rst_release_seq u_dut (.clk(clk), .rst(rst), .bus(if1.slave));
   rst_release_seq #(.ACK_TIMEOUT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if2.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One edge, then settle; acks on if1 mirror ~dom_rst_out three samples late.
   task automatic tick();
      @(posedge clk);
      #1;
      p3 = p2;
      p2 = p1;
      p1 = ~if1.dom_rst_out;
      if1.dom_ack = ack_all ? 3'b111 : (p3 & ack_mask);
   endtask

   task automatic hold_req(input int n);
      if1.rst_req_in = 1'b1;
      repeat (n) tick();
   endtask

   initial begin
      rst = 1'b1;
      if1.rst_req_in = 1'b1;
      if2.rst_req_in = 1'b1;
      if1.dom_ack = '0;
      if2.dom_ack = '0;
      p1 = '0; p2 = '0; p3 = '0;
      ack_mask = 3'b111;
      ack_all  = 1'b0;
      repeat (3) tick();
      chk("rst_dom", 8'(if1.dom_rst_out), 8'h7);
      chk("rst_done", 8'(if1.seq_done), 8'h0);
      chk("rst_err", 8'(if1.seq_err), 8'h0);
      chk("rst_errdom", 8'(if1.err_dom), 8'h0);
      chk("rst_dom2", 8'(if2.dom_rst_out), 8'h7);
      rst = 1'b0;
      repeat (2) tick();
      chk("req_hold", 8'(if1.dom_rst_out), 8'h7);

      // Mirrored acks: ack0 sampled E10, rel1 E22, ack1 E25, rel2 E37, ack2 E40.
      if1.rst_req_in = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (e == 6)  chk("t1_e6", 8'(if1.dom_rst_out), 8'h7);
         if (e == 7)  chk("t1_rel0", 8'(if1.dom_rst_out), 8'h6);
         if (e == 21) chk("t1_e21", 8'(if1.dom_rst_out), 8'h6);
         if (e == 22) chk("t1_rel1", 8'(if1.dom_rst_out), 8'h4);
         if (e == 36) chk("t1_e36", 8'(if1.dom_rst_out), 8'h4);
         if (e == 37) chk("t1_rel2", 8'(if1.dom_rst_out), 8'h0);
         if (e == 39) chk("t1_done_early", 8'(if1.seq_done), 8'h0);
         if (e == 40) chk("t1_done", 8'(if1.seq_done), 8'h1);
      end

      // Async reassert in the middle of the first GAP.
      hold_req(4);
      chk("t4_pre_done", 8'(if1.seq_done), 8'h0);
      if1.rst_req_in = 1'b0;
      for (int e = 1; e <= 15; e++) tick();
      chk("t4_gap_state", 8'(if1.dom_rst_out), 8'h6);
      #2;
      if1.rst_req_in = 1'b1;
      #1;
      chk("t4_async_dom", 8'(if1.dom_rst_out), 8'h7);
      tick();
      chk("t4_edge_dom", 8'(if1.dom_rst_out), 8'h7);
      chk("t4_edge_done", 8'(if1.seq_done), 8'h0);
      hold_req(3);

      // Glitch: three synchronised-low cycles, then one high cycle.
      if1.rst_req_in = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         chk("t2_glitch_lo", 8'(if1.dom_rst_out), 8'h7);
      end
      if1.rst_req_in = 1'b1;
      tick();
      chk("t2_glitch_hi", 8'(if1.dom_rst_out), 8'h7);
      if1.rst_req_in = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e <= 6) chk("t2_no_early", 8'(if1.dom_rst_out), 8'h7);
         if (e == 7) chk("t2_rel0", 8'(if1.dom_rst_out), 8'h6);
      end

      // Acks high up front: releases at E7, E21, E35; done at E37.
      hold_req(4);
      ack_all = 1'b1;
      if1.dom_ack = 3'b111;
      if1.rst_req_in = 1'b0;
      for (int e = 1; e <= 37; e++) begin
         tick();
         if (e == 7)  chk("t5_rel0", 8'(if1.dom_rst_out), 8'h6);
         if (e == 20) chk("t5_e20", 8'(if1.dom_rst_out), 8'h6);
         if (e == 21) chk("t5_rel1", 8'(if1.dom_rst_out), 8'h4);
         if (e == 34) chk("t5_e34", 8'(if1.dom_rst_out), 8'h4);
         if (e == 35) chk("t5_rel2", 8'(if1.dom_rst_out), 8'h0);
         if (e == 36) chk("t5_done_early", 8'(if1.seq_done), 8'h0);
         if (e == 37) chk("t5_done", 8'(if1.seq_done), 8'h1);
      end

      // Domain 1 never acks: rel1 at E22, timeout error at E22+256.
      ack_all = 1'b0;
      ack_mask = 3'b101;
      hold_req(4);
      if1.rst_req_in = 1'b0;
      for (int e = 1; e <= 278; e++) begin
         tick();
         if (e == 22)  chk("t3_rel1", 8'(if1.dom_rst_out), 8'h4);
         if (e == 277) chk("t3_err_early", 8'(if1.seq_err), 8'h0);
         if (e == 278) begin
            chk("t3_err", 8'(if1.seq_err), 8'h1);
            chk("t3_errdom", 8'(if1.err_dom), 8'h1);
            chk("t3_err_dom_rst", 8'(if1.dom_rst_out), 8'h7);
            chk("t3_err_done", 8'(if1.seq_done), 8'h0);
         end
      end
      hold_req(1);
      chk("t3_err_clr", 8'(if1.seq_err), 8'h0);
      chk("t3_errdom_keep", 8'(if1.err_dom), 8'h1);
      tick();
      if1.rst_req_in = 1'b0;
      for (int e = 1; e <= 7; e++) tick();
      chk("t3_reseq", 8'(if1.dom_rst_out), 8'h6);
      chk("t3_reseq_err", 8'(if1.seq_err), 8'h0);

      // ACK_TIMEOUT=4: ack0 arrives on the timeout edge E12; domain 1 times out at E29.
      if2.rst_req_in = 1'b0;
      for (int e = 1; e <= 29; e++) begin
         tick();
         if (e == 7)  chk("t6_rel0", 8'(if2.dom_rst_out), 8'h6);
         if (e == 12) chk("t6_ack_wins", 8'(if2.seq_err), 8'h0);
         if (e == 23) chk("t6_e23", 8'(if2.dom_rst_out), 8'h6);
         if (e == 24) chk("t6_rel1", 8'(if2.dom_rst_out), 8'h4);
         if (e == 28) chk("t6_err_early", 8'(if2.seq_err), 8'h0);
         if (e == 29) begin
            chk("t6_err", 8'(if2.seq_err), 8'h1);
            chk("t6_errdom", 8'(if2.err_dom), 8'h1);
         end
         if (e == 11) if2.dom_ack = 3'b001;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
